ysyx_22040895_wbu: RTL and testbench

//  Writeback unit sitting directly upstream of the integer register file.

---
 rtl/ysyx_22040895_wbu.sv | 139 +++++++++++++
 tb/tb_ysyx_22040895_wbu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_wbu.sv
// Writeback unit: retires one instruction at a time into the integer register file,
// lane-selects and extends load data, and emits a per-instruction commit pulse.
module ysyx_22040895_wbu #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter int PC_W    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_rd_wen,
    input  logic [XLEN-1:0]    in_alu_res,
    input  logic               in_is_load,
    input  logic [1:0]         in_ld_size,
    input  logic               in_ld_unsigned,
    input  logic [2:0]         in_addr_lo,
    input  logic               mem_rvalid,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic               we_o,
    output logic [RADDR_W-1:0] waddr_o,
    output logic [XLEN-1:0]    wdata_o,
    output logic               pend_valid_o,
    output logic [RADDR_W-1:0] pend_rd_o,
    output logic               commit_valid_o,
    output logic [PC_W-1:0]    commit_pc_o,
    output logic               err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t             state;
    logic               rd_wen_q;
    logic               err_q;
    logic [PC_W-1:0]    pc_q;
    logic [RADDR_W-1:0] rd_q;
    logic [XLEN-1:0]    result_q;
    logic [1:0]         ld_size_q;
    logic               ld_unsigned_q;
    logic [2:0]         addr_lo_q;

    logic accept;
    logic stray_rvalid;
    logic misalign;
    logic commit;
    logic rd_live;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo);
        logic m;
        case (size)
            2'd0:    m = 1'b0;
            2'd1:    m = lo[0];
            2'd2:    m = |lo[1:0];
            default: m = |lo;
        endcase
        return m;
    endfunction

    // Bytes shifted in above the top of the word read as zero, which is what a
    // misaligned access crossing the 8-byte boundary should see.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                    input logic [2:0]      lo,
                                                    input logic [1:0]      size,
                                                    input logic            uns);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] ext;
        sh = word >> {lo, 3'b000};
        case (size)
            2'd0:    ext = {{(XLEN-8){sh[7] & ~uns}}, sh[7:0]};
            2'd1:    ext = {{(XLEN-16){sh[15] & ~uns}}, sh[15:0]};
            2'd2:    ext = {{(XLEN-32){sh[31] & ~uns}}, sh[31:0]};
            default: ext = sh;
        endcase
        return ext;
    endfunction

    assign in_ready     = (state == IDLE) && !rst;
    assign accept       = in_valid && in_ready;
    assign stray_rvalid = mem_rvalid && (state != WAIT_MEM);
    assign misalign     = accept && in_is_load && is_misaligned(in_ld_size, in_addr_lo);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_wen_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_q | stray_rvalid | misalign;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rd_wen_q <= in_rd_wen;
                        state    <= in_is_load ? WAIT_MEM : WRITE;
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        state <= WRITE;
                    end
                end
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; every output they feed is qualified by state.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_q          <= in_pc;
            rd_q          <= in_rd;
            result_q      <= in_alu_res;
            ld_size_q     <= in_ld_size;
            ld_unsigned_q <= in_ld_unsigned;
            addr_lo_q     <= in_addr_lo;
        end else if (state == WAIT_MEM && mem_rvalid) begin
            result_q <= load_extend(mem_rdata, addr_lo_q, ld_size_q, ld_unsigned_q);
        end
    end

    assign commit  = (state == WRITE) && !rst;
    assign rd_live = rd_wen_q && (rd_q != '0);

    assign commit_valid_o = commit;
    assign commit_pc_o    = commit ? pc_q : '0;
    assign we_o           = commit && rd_live;
    assign waddr_o        = we_o ? rd_q : '0;
    assign wdata_o        = we_o ? result_q : '0;
    assign pend_valid_o   = (state != IDLE) && !rst && rd_live;
    assign pend_rd_o      = pend_valid_o ? rd_q : '0;
    assign err_o          = err_q;

endmodule

// File: tb/tb_ysyx_22040895_wbu.sv
// Scoreboard bench for the writeback unit: directed ALU/load ops push expected
// commits; a negedge monitor pops and compares whenever a commit is presented.
module tb_ysyx_22040895_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [63:0] in_alu_res;
    logic        in_is_load;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic [2:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [63:0] wdata_o;
    logic        pend_valid_o;
    logic [4:0]  pend_rd_o;
    logic        commit_valid_o;
    logic [63:0] commit_pc_o;
    logic        err_o;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic [63:0] pc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ysyx_22040895_wbu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_alu_res(in_alu_res),
        .in_is_load(in_is_load), .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
        .in_addr_lo(in_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .pend_valid_o(pend_valid_o), .pend_rd_o(pend_rd_o),
        .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o), .err_o(err_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (commit_valid_o) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_commit: got pc 0x%0h expected no commit", commit_pc_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_we", 64'(we_o), 64'(e.we));
                chk("sb_waddr", 64'(waddr_o), 64'(e.waddr));
                chk("sb_wdata", wdata_o, e.wdata);
                chk("sb_pc", commit_pc_o, e.pc);
            end
        end
    end

    function automatic exp_t mk(input logic [63:0] pc, input logic [4:0] rd,
                                input logic wen, input logic [63:0] v);
        exp_t e;
        e.we    = wen && (rd != 5'd0);
        e.waddr = e.we ? rd : 5'd0;
        e.wdata = e.we ? v : 64'd0;
        e.pc    = pc;
        return e;
    endfunction

    task automatic issue(input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                         input logic [63:0] alu, input logic ld, input logic [1:0] size,
                         input logic uns, input logic [2:0] lo);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_pc = pc; in_rd = rd; in_rd_wen = wen; in_alu_res = alu;
        in_is_load = ld; in_ld_size = size; in_ld_unsigned = uns; in_addr_lo = lo;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic alu_op(input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                          input logic [63:0] alu);
        q.push_back(mk(pc, rd, wen, alu));
        issue(pc, rd, wen, alu, 1'b0, 2'd0, 1'b0, 3'd0);
        @(negedge clk);
        chk("alu_latency", 64'(commit_valid_o), 64'd1);
        chk("alu_pend", 64'(pend_valid_o), 64'(wen && rd != 5'd0));
        chk("alu_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("alu_single", 64'(commit_valid_o), 64'd0);
    endtask

    task automatic load_op(input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                           input logic [1:0] size, input logic uns, input logic [2:0] lo,
                           input logic [63:0] rdata, input int dly, input logic [63:0] expv);
        q.push_back(mk(pc, rd, wen, expv));
        issue(pc, rd, wen, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, size, uns, lo);
        @(negedge clk);
        chk("ld_wait_ready", 64'(in_ready), 64'd0);
        chk("ld_pend", 64'(pend_valid_o), 64'(wen && rd != 5'd0));
        chk("ld_pend_rd", 64'(pend_rd_o), (wen && rd != 5'd0) ? 64'(rd) : 64'd0);
        repeat (dly) @(negedge clk);
        chk("ld_no_early", 64'(commit_valid_o), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(posedge clk);
        #1 mem_rvalid = 1'b0; mem_rdata = 64'h0;
        @(negedge clk);
        chk("ld_latency", 64'(commit_valid_o), 64'd1);
        @(negedge clk);
        chk("ld_single", 64'(commit_valid_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_rd = '0; in_rd_wen = 1'b0;
        in_alu_res = '0; in_is_load = 1'b0; in_ld_size = '0; in_ld_unsigned = 1'b0;
        in_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_we", 64'(we_o), 64'd0);
        chk("rst_commit", 64'(commit_valid_o), 64'd0);
        chk("rst_pend", 64'(pend_valid_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", 64'(in_ready), 64'd1);

        alu_op(64'h8000_0000, 5'd5, 1'b1, 64'h1234);
        alu_op(64'h8000_0010, 5'd9, 1'b0, 64'h5555);
        load_op(64'h8000_0004, 5'd6, 1'b1, 2'd0, 1'b0, 3'd3, 64'h0000_0000_8000_0000, 0,
                64'hFFFF_FFFF_FFFF_FF80);
        load_op(64'h8000_0008, 5'd7, 1'b1, 2'd0, 1'b1, 3'd3, 64'h0000_0000_8000_0000, 0,
                64'h80);
        load_op(64'h8000_000C, 5'd8, 1'b1, 2'd2, 1'b0, 3'd4, 64'h8765_4321_0000_0000, 5,
                64'hFFFF_FFFF_8765_4321);
        load_op(64'h8000_0014, 5'd10, 1'b1, 2'd2, 1'b1, 3'd4, 64'h8765_4321_0000_0000, 1,
                64'h0000_0000_8765_4321);
        load_op(64'h8000_0018, 5'd11, 1'b1, 2'd1, 1'b0, 3'd2, 64'h0000_0000_8001_0000, 0,
                64'hFFFF_FFFF_FFFF_8001);
        load_op(64'h8000_001C, 5'd12, 1'b1, 2'd1, 1'b1, 3'd2, 64'h0000_0000_8001_0000, 2,
                64'h8001);
        load_op(64'h8000_0020, 5'd13, 1'b1, 2'd3, 1'b1, 3'd0, 64'h8000_0000_0000_0001, 0,
                64'h8000_0000_0000_0001);
        chk("aligned_no_err", 64'(err_o), 64'd0);

        load_op(64'h8000_0024, 5'd0, 1'b1, 2'd2, 1'b0, 3'd0, 64'h1111_2222, 1, 64'h0);
        alu_op(64'h8000_0028, 5'd0, 1'b1, 64'h7777);

        // Reset while a load waits for memory: op must vanish with no write or commit.
        issue(64'h8000_0030, 5'd14, 1'b1, 64'h0, 1'b1, 2'd3, 1'b0, 3'd0);
        @(negedge clk);
        chk("rst_case_pend", 64'(pend_valid_o), 64'd1);
        rst = 1'b1;
        #1 chk("rst_case_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_case_ready", 64'(in_ready), 64'd1);
        chk("rst_case_pend0", 64'(pend_valid_o), 64'd0);
        chk("rst_case_commit0", 64'(commit_valid_o), 64'd0);
        @(negedge clk);
        chk("rst_case_commit1", 64'(commit_valid_o), 64'd0);
        alu_op(64'h8000_0034, 5'd15, 1'b1, 64'hCAFE);

        // Stray mem_rvalid in IDLE sets a sticky error.
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
        @(negedge clk);
        chk("stray_err", 64'(err_o), 64'd1);
        chk("stray_no_commit", 64'(commit_valid_o), 64'd0);
        repeat (4) @(negedge clk);
        chk("stray_err_sticky", 64'(err_o), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("err_cleared", 64'(err_o), 64'd0);

        // LH at lane 7: only one real byte available, upper byte reads as zero.
        load_op(64'h8000_0040, 5'd16, 1'b1, 2'd1, 1'b0, 3'd7, 64'hFF00_0000_0000_0000, 1,
                64'hFF);
        chk("misalign_err", 64'(err_o), 64'd1);
        alu_op(64'h8000_0044, 5'd17, 1'b1, 64'h42);
        chk("misalign_err_sticky", 64'(err_o), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("err_cleared2", 64'(err_o), 64'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
